// File: rtl/delay_line_bank.sv
// rtl/delay_line_bank.sv - multi-channel recirculating serial delay line, one revolution of BITS slots
// Memory is zero-swept in CLEAR, then slots are sampled, stored and replayed one revolution later in RUN.
module delay_line_bank #(
  parameter int CLK_FREQ     = 81_000_000,
  parameter int BIT_CYCLES   = 154,
  parameter int BITS         = 576,
  parameter int CHANNELS     = 1,
  parameter int SAMPLE_PHASE = BIT_CYCLES / 2,
  parameter int RZ_CYCLES    = 0
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] recirc,
  output logic [CHANNELS-1:0] out,
  output logic                frame_sync,
  output logic                ready
);

  localparam int PH_W  = $clog2(BIT_CYCLES);
  localparam int PTR_W = $clog2(BITS);
  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(SAMPLE_PHASE);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BIT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BITS - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_clr_addr;
  logic [PTR_W-1:0]    r_ptr;
  logic [PH_W-1:0]     r_ph;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] r_slot;
  logic [CHANNELS-1:0] r_sample;
  logic [CHANNELS-1:0] r_out;
  logic                r_frame_sync;
  logic                r_ready;
  logic [CHANNELS-1:0] r_mem [BITS];

  logic                w_slot_end;
  logic [PTR_W-1:0]    w_ptr_inc;
  logic [PH_W-1:0]     w_ph_next;
  logic [PTR_W-1:0]    w_ptr_next;
  logic [CHANNELS-1:0] w_slot_next;
  logic [CHANNELS-1:0] w_out_next;
  logic                w_mem_we;
  logic [PTR_W-1:0]    w_mem_addr;
  logic [CHANNELS-1:0] w_mem_wdata;

  assign w_slot_end  = (r_ph == PH_LAST);
  assign w_ptr_inc   = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
  assign w_ph_next   = w_slot_end ? '0 : r_ph + 1'b1;
  assign w_ptr_next  = w_slot_end ? w_ptr_inc : r_ptr;
  // The next slot is read in the same cycle mem[ptr] is written; addresses differ, so this is pre-write data.
  assign w_slot_next = w_slot_end ? r_mem[w_ptr_inc] : r_slot;

  generate
    if (RZ_CYCLES == 0) begin : g_nrz
      assign w_out_next = w_slot_next;
    end else begin : g_rz
      localparam logic [PH_W-1:0] PH_RZ = PH_W'(RZ_CYCLES);
      assign w_out_next = (w_ph_next < PH_RZ) ? w_slot_next : '0;
    end
  endgenerate

  assign w_mem_we    = n_reset && ((r_state == S_CLEAR) || w_slot_end);
  assign w_mem_addr  = (r_state == S_CLEAR) ? r_clr_addr : r_ptr;
  assign w_mem_wdata = (r_state == S_CLEAR) ? '0 : r_sample;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state      <= S_CLEAR;
      r_clr_addr   <= '0;
      r_ph         <= '0;
      r_ptr        <= '0;
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_slot       <= '0;
      r_sample     <= '0;
      r_out        <= '0;
      r_frame_sync <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
      case (r_state)
        S_CLEAR: begin
          if (r_clr_addr == PTR_LAST) begin
            r_state      <= S_RUN;
            r_ph         <= '0;
            r_ptr        <= '0;
            r_slot       <= '0;
            r_out        <= '0;
            r_frame_sync <= 1'b1;
            r_ready      <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        S_RUN: begin
          r_ph         <= w_ph_next;
          r_ptr        <= w_ptr_next;
          r_slot       <= w_slot_next;
          r_out        <= w_out_next;
          r_frame_sync <= (w_ph_next == '0) && (w_ptr_next == '0);
          r_ready      <= 1'b1;
          if (r_ph == PH_SAMPLE) begin
            r_sample <= r_sync2 | (recirc & r_slot);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    assert (CLK_FREQ > 0 && BIT_CYCLES >= 4 && BITS >= 2 && CHANNELS >= 1 &&
            SAMPLE_PHASE >= 0 && SAMPLE_PHASE <= BIT_CYCLES - 2 &&
            (RZ_CYCLES == 0 || (RZ_CYCLES >= 1 && RZ_CYCLES < BIT_CYCLES)));
  end

  assign out        = r_out;
  assign frame_sync = r_frame_sync;
  assign ready      = r_ready;

endmodule

// File: tb/tb_delay_line_bank.sv
// tb/tb_delay_line_bank.sv - directed bench for delay_line_bank, NRZ and RZ instances sharing stimulus
module tb_delay_line_bank;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [1:0] in;
  logic [1:0] recirc;
  logic [1:0] out;
  logic [1:0] out_rz;
  logic       fs;
  logic       fs_rz;
  logic       rdy;
  logic       rdy_rz;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int run_t    = 0;

  always #5 clk = ~clk;

  delay_line_bank #(
    .CLK_FREQ(80_000_000), .BIT_CYCLES(8), .BITS(16), .CHANNELS(2),
    .SAMPLE_PHASE(4), .RZ_CYCLES(0)
  ) u_nrz (
    .clk(clk), .n_reset(n_reset), .in(in), .recirc(recirc),
    .out(out), .frame_sync(fs), .ready(rdy)
  );

  delay_line_bank #(
    .CLK_FREQ(80_000_000), .BIT_CYCLES(8), .BITS(16), .CHANNELS(2),
    .SAMPLE_PHASE(4), .RZ_CYCLES(3)
  ) u_rz (
    .clk(clk), .n_reset(n_reset), .in(in), .recirc(recirc),
    .out(out_rz), .frame_sync(fs_rz), .ready(rdy_rz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, run_t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    run_t++;
  endtask

  task automatic goto(input int t);
    while (run_t < t) step();
  endtask

  // Called on a negedge; the CLEAR sweep takes 16 cycles, RUN starts in cycle 17.
  task automatic release_reset();
    n_reset = 1'b1;
    check("clr_ready_c1", {30'd0, rdy_rz, rdy}, 32'd0);
    check("clr_out_c1", {28'd0, out_rz, out}, 32'd0);
    for (int i = 2; i <= 16; i++) begin
      step();
      check("clr_ready", {30'd0, rdy_rz, rdy}, 32'd0);
      check("clr_out_fs", {26'd0, fs_rz, fs, out_rz, out}, 32'd0);
    end
    step();
    check("run_ready", {30'd0, rdy_rz, rdy}, 32'd3);
    check("run_first_fs", {30'd0, fs_rz, fs}, 32'd3);
    run_t = 0;
  endtask

  initial begin
    n_reset = 1'b0;
    in      = 2'b00;
    recirc  = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {30'd0, rdy_rz, rdy}, 32'd0);
    check("rst_fs", {30'd0, fs_rz, fs}, 32'd0);
    check("rst_out", {28'd0, out_rz, out}, 32'd0);
    release_reset();

    goto(1);   check("fs_t1", {31'd0, fs}, 32'd0);
    goto(24);  in[0] = 1'b1;
    goto(32);  in[0] = 1'b0;
    goto(40);  in[1] = 1'b1;
    goto(41);  in[1] = 1'b0;
    goto(50);  in[1] = 1'b1;
    goto(51);  in[1] = 1'b0;
    goto(127); check("fs_t127", {31'd0, fs}, 32'd0);
    goto(128); check("fs_t128", {30'd0, fs_rz, fs}, 32'd3);
    goto(129); check("fs_t129", {31'd0, fs}, 32'd0);

    goto(151); check("slot18_out", {30'd0, out}, 32'd0);
    for (int t = 152; t < 160; t++) begin
      goto(t);
      check("slot19_out", {30'd0, out}, 32'd1);
      check("slot19_rz", {30'd0, out_rz}, (t - 152 < 3) ? 32'd1 : 32'd0);
    end
    goto(160); check("slot20_out", {30'd0, out}, 32'd0);
    goto(172); check("slot21_short_pulse", {30'd0, out}, 32'd0);
    goto(180); check("slot22_edge_pulse", {30'd0, out}, 32'd2);
    goto(256); check("fs_t256", {31'd0, fs}, 32'd1);

    goto(280); recirc = 2'b01; in[0] = 1'b1;
    check("slot35_out", {30'd0, out}, 32'd0);
    goto(284); check("slot35_out_mid", {30'd0, out}, 32'd0);
    goto(288); in[0] = 1'b0;
    goto(306); check("slot38_replaced", {30'd0, out}, 32'd0);
    goto(410); check("slot51_recirc", {30'd0, out}, 32'd1);
    goto(540); check("slot67_recirc", {30'd0, out}, 32'd1);
    goto(668); check("slot83_recirc", {30'd0, out}, 32'd1);
    goto(680); recirc = 2'b00;
    goto(794); check("slot99_last", {30'd0, out}, 32'd1);
    goto(922); check("slot115_gone", {30'd0, out}, 32'd0);

    goto(928); recirc = 2'b11;
    goto(936); in = 2'b11;
    goto(944); in = 2'b00;
    goto(1066); check("slot133_out", {30'd0, out}, 32'd3);
    check("slot133_rz_ph2", {30'd0, out_rz}, 32'd3);
    goto(1067); check("slot133_rz_ph3", {30'd0, out_rz}, 32'd0);
    check("slot133_out_ph3", {30'd0, out}, 32'd3);

    goto(1104); n_reset = 1'b0;
    step();
    check("midrun_rst_ready", {30'd0, rdy_rz, rdy}, 32'd0);
    check("midrun_rst_out", {26'd0, fs_rz, fs, out_rz, out}, 32'd0);
    release_reset();
    for (int t = 1; t < 128; t++) begin
      goto(t);
      check("post_rst_out", {28'd0, out_rz, out}, 32'd0);
    end
    goto(128); check("post_rst_fs", {30'd0, fs_rz, fs}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/delay_line_bank.md
DELAY_LINE_BANK -- requirements
Module: delay_line_bank

Interface
REQ-001 Parameter CLK_FREQ, default 81_000_000, clock frequency in Hz; used only for documentation and assertions.
REQ-002 Parameter BIT_CYCLES, default 154, clock cycles per bit slot; SHALL be >= 4.
REQ-003 Parameter BITS, default 576, bit slots per revolution (line depth); SHALL be >= 2.
REQ-004 Parameter CHANNELS, default 1, number of independent delay lines; SHALL be >= 1.
REQ-005 Parameter SAMPLE_PHASE, default BIT_CYCLES/2, slot phase at which input is sampled; SHALL satisfy 0 <= SAMPLE_PHASE <= BIT_CYCLES-2.
REQ-006 Parameter RZ_CYCLES, default 0, output pulse width in cycles; 0 = NRZ; otherwise SHALL satisfy 1 <= RZ_CYCLES < BIT_CYCLES.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 n_reset  input  1  reset, synchronous, active-low.
REQ-009 in  input  CHANNELS  asynchronous serial data, one bit per channel.
REQ-010 recirc  input  CHANNELS  per-channel mode: 1 = recirculate, 0 = replace.
REQ-011 out  output  CHANNELS  delayed serial data, registered.
REQ-012 frame_sync  output  1  one-cycle pulse at the start of slot 0.
REQ-013 ready  output  1  high when the line is in RUN.

Function
REQ-014 Each in bit SHALL pass through a 2-flop synchroniser; recirc SHALL be used unsynchronised (quasi-static).
REQ-015 Storage SHALL be one BITS x CHANNELS memory; each address holds one slot for all channels.
REQ-016 Counters: phase ph in 0..BIT_CYCLES-1 and pointer ptr in 0..BITS-1; ph increments each RUN cycle; at BIT_CYCLES-1 it wraps to 0 and ptr increments; ptr wraps BITS-1 -> 0.
REQ-017 The state machine SHALL have two states: CLEAR and RUN.
REQ-018 In CLEAR, the block SHALL write zero to one address per cycle, 0 to BITS-1; after writing address BITS-1 it SHALL enter RUN with ph=0, ptr=0.
REQ-019 In CLEAR, out, frame_sync and ready SHALL be 0.
REQ-020 In RUN, at ph==SAMPLE_PHASE, per channel the sample SHALL capture in_sync when recirc=0, or (in_sync OR current slot bit) when recirc=1.
REQ-021 At ph==BIT_CYCLES-1, the captured sample SHALL be written to mem[ptr]; the read for the next slot SHALL return the pre-write contents of mem[ptr+1 mod BITS].
REQ-022 Delay: a bit captured in slot p SHALL appear on out during slot p+BITS, exactly one revolution later.
REQ-023 With RZ_CYCLES=0, out SHALL hold the slot bit for all BIT_CYCLES cycles; with RZ_CYCLES=R, out SHALL be the slot bit for ph<R and 0 otherwise.
REQ-024 frame_sync SHALL be 1 exactly in cycles where state=RUN, ph=0 and ptr=0.
REQ-025 ready SHALL be 1 in every RUN cycle, including the first one.
REQ-026 Pulses on in that do not span the synchronised sample point SHALL NOT be stored; no edge detection.
REQ-027 Channels SHALL be fully independent; a recirc change takes effect at the next sample point.

Reset
REQ-028 When n_reset=0 at a clock edge, the block SHALL set state=CLEAR, clear address=0, ph=0, ptr=0, out=0, frame_sync=0, ready=0 and synchroniser flops=0.
REQ-029 Reset asserted mid-RUN SHALL discard all stored data; the full CLEAR sweep SHALL run again after release.
REQ-030 Reset length SHALL have no minimum beyond one cycle.

Verification (BIT_CYCLES=8, BITS=16, CHANNELS=2, SAMPLE_PHASE=4, RZ_CYCLES=0 unless stated)
REQ-031 Release reset -> ready=0 and out=0 for 16 cycles; on cycle 17 ready=1 and frame_sync=1 for one cycle; frame_sync repeats every 128 cycles.
REQ-032 recirc=00; hold in[0]=1 over slot 3 only -> out[0]=1 for all 8 cycles of slot 19; 0 in slot 35; out[1]=0 throughout.
REQ-033 recirc=01; same stimulus -> out[0]=1 in slots 19, 35, 51, ... indefinitely; set recirc[0]=0 with in=0 -> the bit is gone one revolution later.
REQ-034 RZ_CYCLES=3; stored 1 -> out high for ph 0..2 only, low for ph 3..7 of that slot.
REQ-035 Store a pattern, then assert reset for 1 cycle in slot 10 -> CLEAR repeats (16 cycles), after which out stays 0 for a full revolution.
REQ-036 A 1-cycle in pulse at ph 0 of slot 5 -> not captured; out=0 in slot 21.
